// File: rtl/transport_receive_pkg.sv
// Transport protocol definitions shared by the sender and the receiver.
// Covers the framing bytes, the output word commands and the receive FSM states.
package transport_receive_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] TRAILER   = 8'hFF;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    localparam int WORD_W = 18;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_CTRL  = 2'b01,
        CMD_AUDIO = 2'b10
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CTRL_HI = 3'd1,
        CTRL_LO = 3'd2,
        AUD_HI  = 3'd3,
        AUD_LO  = 3'd4,
        TRAIL   = 3'd5,
        SKIP    = 3'd6
    } rx_state_e;

    typedef struct packed {
        cmd_e        cmd;
        logic [15:0] data;
    } rx_word_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle; otherwise it is dropped.
module rx_word_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;

    logic pop_ok;
    logic push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && full_o && !pop_ok;

    // Combinational read of the head entry gives fall-through without an extra cycle.
    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/transport_receive.sv
// Byte-stream transport receiver: frames fixed-size packets, decodes control and
// audio payloads into 18-bit {cmd, data} words and queues them in an output FIFO.
module transport_receive
    import transport_receive_pkg::*;
#(
    parameter int PACKET_SIZE = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    packetIn,
    input  logic                          rcvValid,
    output logic [1:0]                    out_cmd,
    output logic [15:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          pkt_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(PACKET_SIZE);
    localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(PACKET_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(PACKET_SIZE - 2);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       hi_q,    hi_d;
    logic             push_q,  push_d;
    rx_word_t         word_q,  word_d;
    logic             err_q,   err_d;
    logic             overflow_q;

    logic [WORD_W-1:0] head_raw;
    rx_word_t          head_word;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_drop;

    // cnt_q is the index of the next byte expected within the current packet.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        push_d  = 1'b0;
        word_d  = word_q;
        err_d   = 1'b0;

        if (rcvValid) begin
            case (state_q)
                IDLE: begin
                    if (packetIn == IDLE_BYTE) begin
                        state_d = IDLE;
                    end else if (packetIn == HDR_CTRL) begin
                        state_d = CTRL_HI;
                        cnt_d   = CNT_W'(1);
                    end else if (packetIn == HDR_AUDIO) begin
                        state_d = AUD_HI;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                        cnt_d   = CNT_W'(1);
                    end
                end
                CTRL_HI: begin
                    hi_d    = packetIn;
                    state_d = CTRL_LO;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                CTRL_LO: begin
                    push_d      = 1'b1;
                    word_d.cmd  = CMD_CTRL;
                    word_d.data = {hi_q, packetIn};
                    state_d     = SKIP;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
                AUD_HI: begin
                    hi_d    = packetIn;
                    state_d = AUD_LO;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                AUD_LO: begin
                    push_d      = 1'b1;
                    word_d.cmd  = CMD_AUDIO;
                    word_d.data = {hi_q, packetIn};
                    state_d     = (cnt_q == LAST_SAMPLE) ? TRAIL : AUD_HI;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
                TRAIL: begin
                    err_d   = (packetIn != TRAILER);
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                SKIP: begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            push_q  <= 1'b0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            push_q  <= push_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Completed words are staged one cycle before entering the FIFO.
    rx_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_q),
        .push_data_i (word_q),
        .pop_i       (out_ready),
        .head_data_o (head_raw),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign head_word = head_raw;
    assign out_valid = !fifo_empty;
    assign out_cmd   = out_valid ? head_word.cmd  : CMD_IDLE;
    assign out_data  = out_valid ? head_word.data : 16'h0000;
    assign busy      = (state_q != IDLE);
    assign pkt_err   = err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_transport_receive.sv
// Directed bench for transport_receive with a byte-position reference model and
// a per-cycle compare process, plus literal expectations from hand-worked packets.
module tb_transport_receive;

    localparam int PS = 16;
    localparam int FD = 16;
    localparam int CW = $clog2(FD) + 1;

    logic          clk;
    logic          reset;
    logic [7:0]    packetIn;
    logic          rcvValid;
    logic [1:0]    out_cmd;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          pkt_err;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    int errors = 0;
    int checks = 0;

    transport_receive #(
        .PACKET_SIZE (PS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .packetIn   (packetIn),
        .rcvValid   (rcvValid),
        .out_cmd    (out_cmd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .pkt_err    (pkt_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet position counter and a word queue.
    int          m_pos;
    int          m_type;      // 1 control, 2 audio, 0 unknown header
    logic [7:0]  m_hi;
    logic [17:0] m_q[$];
    bit          m_pend;
    logic [17:0] m_pend_word;
    bit          m_err;
    bit          m_ovf;
    bit          m_busy;
    bit          model_on = 0;
    bit          m_pop;
    int          m_size;

    always @(posedge clk) begin
        if (reset) begin
            m_pos = 0; m_type = 0; m_pend = 0; m_err = 0; m_ovf = 0; m_busy = 0;
            m_q.delete();
            model_on = 1;
        end else begin
            m_size = m_q.size();
            m_pop  = out_ready && (m_size > 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_size == FD && !m_pop) m_ovf = 1;
                else m_q.push_back(m_pend_word);
            end
            m_pend = 0;
            m_err  = 0;
            if (rcvValid) begin
                if (m_pos == 0) begin
                    if (packetIn != 8'h00) begin
                        m_pos = 1;
                        if (packetIn == 8'h40) m_type = 1;
                        else if (packetIn == 8'h80) m_type = 2;
                        else begin m_type = 0; m_err = 1; end
                    end
                end else begin
                    if (m_type == 1) begin
                        if (m_pos == 1) m_hi = packetIn;
                        else if (m_pos == 2) begin
                            m_pend = 1; m_pend_word = {2'b01, m_hi, packetIn};
                        end
                    end else if (m_type == 2) begin
                        if (m_pos <= PS - 2) begin
                            if (m_pos % 2 == 1) m_hi = packetIn;
                            else begin m_pend = 1; m_pend_word = {2'b10, m_hi, packetIn}; end
                        end else if (packetIn != 8'hFF) m_err = 1;
                    end
                    m_pos = (m_pos == PS - 1) ? 0 : m_pos + 1;
                end
            end
            m_busy = (m_pos != 0);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("cyc_fifo_count", 32'(fifo_count), 32'(m_q.size()));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_pkt_err", 32'(pkt_err), 32'(m_err));
            chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
            if (m_q.size() != 0) chk("cyc_head", 32'({out_cmd, out_data}), 32'(m_q[0]));
        end
    end

    task automatic send(input logic [7:0] b);
        packetIn = b;
        rcvValid = 1'b1;
        @(negedge clk);
        rcvValid = 1'b0;
    endtask

    task automatic send_ctrl(input logic [15:0] w);
        send(8'h40);
        send(w[15:8]);
        send(w[7:0]);
        repeat (PS - 3) send(8'h00);
    endtask

    task automatic send_audio(input logic [15:0] base, input logic [7:0] trl, input bit gapped);
        logic [15:0] s;
        send(8'h80);
        for (int i = 0; i < (PS - 2) / 2; i++) begin
            s = base + 16'(i);
            send(s[15:8]);
            if (gapped && (i % 3 == 0)) @(negedge clk);
            send(s[7:0]);
        end
        send(trl);
    endtask

    task automatic drain_expect(input logic [17:0] first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_word", 32'({out_cmd, out_data}), 32'(first + 18'(i)));
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rcvValid = 1'b0; packetIn = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Control packet: word visible two edges after byte 2.
        send(8'h40); send(8'h12); send(8'h34);
        chk("ctrl_lat_early", 32'(out_valid), 32'd0);
        chk("ctrl_busy", 32'(busy), 32'd1);
        send(8'h00);
        chk("ctrl_lat_valid", 32'(out_valid), 32'd1);
        chk("ctrl_word", 32'({out_cmd, out_data}), 32'h11234);
        repeat (PS - 4) send(8'h00);
        chk("ctrl_idle_after", 32'(busy), 32'd0);
        chk("ctrl_no_err", 32'(pkt_err), 32'd0);
        send(8'h00);
        chk("filler_idle", 32'(busy), 32'd0);
        drain_expect(18'h11234, 1);
        chk("ctrl_empty", 32'(fifo_count), 32'd0);

        // Audio packet with gaps.
        send_audio(16'h0001, 8'hFF, 1'b1);
        chk("aud_no_err", 32'(pkt_err), 32'd0);
        drain_expect(18'h20001, 7);

        // Bad trailer, then a control packet with no bubble.
        send_audio(16'h0101, 8'hFE, 1'b0);
        chk("bad_trl_err", 32'(pkt_err), 32'd1);
        send_ctrl(16'h5678);
        chk("bad_trl_err_gone", 32'(pkt_err), 32'd0);
        drain_expect(18'h20101, 7);
        drain_expect(18'h15678, 1);

        // Unknown header; embedded 0x40 must be skipped.
        send(8'h55);
        chk("unk_err", 32'(pkt_err), 32'd1);
        for (int i = 1; i < PS; i++) send((i == 3) ? 8'h40 : 8'(i));
        chk("unk_idle", 32'(busy), 32'd0);
        chk("unk_nothing", 32'(fifo_count), 32'd0);
        send_ctrl(16'h9ABC);
        drain_expect(18'h19ABC, 1);

        // Overflow: 21 words into 16 entries.
        send_audio(16'h1000, 8'hFF, 1'b0);
        send_audio(16'h1010, 8'hFF, 1'b0);
        send_audio(16'h1020, 8'hFF, 1'b0);
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'({out_cmd, out_data}), 32'h21000);
        // Push and pop on the same edge while full.
        send(8'h80); send(8'h20); send(8'h00);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("full_pushpop_count", 32'(fifo_count), 32'd16);
        chk("full_pushpop_head", 32'({out_cmd, out_data}), 32'h21001);
        for (int i = 1; i < 7; i++) begin send(8'h20); send(8'(i)); end
        send(8'hFF);
        drain_expect(18'h21001, 6);
        drain_expect(18'h21010, 7);
        drain_expect(18'h21020, 2);
        drain_expect(18'h22000, 1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset after byte 5 of an audio packet.
        send(8'h80); send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        reset = 1'b1; rcvValid = 1'b1; packetIn = 8'h40;
        repeat (2) @(negedge clk);
        reset = 1'b0; rcvValid = 1'b0;
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_err", 32'(pkt_err), 32'd0);
        send_ctrl(16'hABCD);
        drain_expect(18'h1ABCD, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transport_receive.md
TRANSPORT_RECEIVE -- requirements
Module: transport_receive

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 16, packet length in bytes; even and >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output word FIFO entries; power of two.
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 packetIn  input  8  received byte.
REQ-006 rcvValid  input  1  packetIn valid this cycle; one byte per high cycle; gaps allowed.
REQ-007 out_cmd  output  2  command of the head word: 2'b01 control, 2'b10 audio.
REQ-008 out_data  output  16  data of the head word.
REQ-009 out_valid  output  1  FIFO non-empty; out_cmd/out_data valid.
REQ-010 out_ready  input  1  consumer pops the head word on a cycle where out_valid=1 and out_ready=1.
REQ-011 busy  output  1  high while a packet is partially received.
REQ-012 pkt_err  output  1  one-cycle pulse on a malformed packet.
REQ-013 overflow  output  1  sticky; set when a word is dropped because the FIFO is full.
REQ-014 fifo_count  output  clog2(FIFO_DEPTH)+1  number of words held.

Function
REQ-015 Packet framing SHALL be: byte 0 header; bytes 1..PACKET_SIZE-1 body; byte counter advances only on rcvValid.
REQ-016 FSM states SHALL be IDLE, CTRL_HI, CTRL_LO, AUD_HI, AUD_LO, TRAIL, SKIP.
REQ-017 IDLE, byte 0x00: ignored, no error, counter unchanged (idle filler).
REQ-018 IDLE, byte 0x40: go to CTRL_HI; byte 0x80: go to AUD_HI; any other byte: pkt_err pulse, go to SKIP.
REQ-019 Control packet: byte 1 = data[15:8], byte 2 = data[7:0]; on byte 2, push {2'b01, word}; bytes 3..PACKET_SIZE-1 consumed in SKIP without checking.
REQ-020 Audio packet: bytes 1..PACKET_SIZE-2 = (PACKET_SIZE-2)/2 samples, high byte first; each sample pushed as {2'b10, word} when its low byte arrives.
REQ-021 Audio byte PACKET_SIZE-1 (TRAIL) SHALL equal 0xFF; otherwise pkt_err pulse; already-pushed samples are kept.
REQ-022 SKIP SHALL consume bytes until byte PACKET_SIZE-1, then return to IDLE.
REQ-023 After the last byte of any packet, the FSM SHALL be in IDLE on the next cycle; the next byte is treated as a header.
REQ-024 busy SHALL be 0 in IDLE and 1 in every other state.
REQ-025 pkt_err SHALL be asserted in the cycle after the offending byte is sampled, for exactly one cycle.
REQ-026 Latency: a word completed by a byte sampled at edge k SHALL be visible with out_valid=1 after edge k+1 (first-word-fall-through).
REQ-027 Push when full and no pop: word dropped, overflow set, FSM continues normally.
REQ-028 Push and pop in the same cycle while full: both succeed and fifo_count is unchanged.
REQ-029 Pop when empty SHALL be ignored.
REQ-030 fifo_count SHALL be exact every cycle; read and write pointers wrap modulo FIFO_DEPTH.
REQ-031 A header byte may arrive in the cycle immediately after the previous packet's last byte, with no bubble required.

Reset
REQ-032 Reset SHALL force: FSM to IDLE, byte counter 0, FIFO emptied, out_valid=0, busy=0, pkt_err=0, overflow=0, fifo_count=0.
REQ-033 Reset mid-packet SHALL discard the partial packet; the first byte after reset SHALL be treated as a header.
REQ-034 While reset is high, bytes on packetIn SHALL be ignored.

Structure
REQ-035 A shared transport package SHALL hold: header constants HDR_CTRL=8'h40, HDR_AUDIO=8'h80, TRAILER=8'hFF, IDLE_BYTE=8'h00; cmd encodings CMD_IDLE/CMD_CTRL/CMD_AUDIO; the FSM state typedef.
REQ-036 The sender block SHALL use the same package.
REQ-037 One sub-module SHALL exist: rx_word_fifo, an 18-bit-wide synchronous FWFT FIFO with a count output.

Verification
REQ-038 Control: PACKET_SIZE=16; bytes 40 12 34 + 13x00 -> one word {01,1234}, out_valid after 2 edges, busy high for 16 bytes, no pkt_err.
REQ-039 Audio: 80, then 7 pairs 0001..0007, then FF -> 7 words {10,0001}..{10,0007} in order; no pkt_err.
REQ-040 Bad trailer: audio packet ending in 0xFE -> 7 samples delivered, one pkt_err pulse; next control packet decoded correctly.
REQ-041 Unknown header 0x55 -> pkt_err pulse, next 15 bytes (including a 0x40 among them) ignored, following packet decoded.
REQ-042 Overflow: out_ready=0, 3 audio packets (21 words) -> fifo_count=16, overflow=1, first 16 words intact; same-cycle push+pop at full keeps fifo_count=16.
REQ-043 Reset after byte 5 of an audio packet -> all outputs cleared; next packet 40 AB CD ... -> {01,ABCD}.
